// File: rtl/si_pkg.sv
// Shared definitions for the player bullet path.
// Exports the fire-control state encoding, the default fire keycode and a
// saturating increment that is also used by the score counters.
package si_pkg;

  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam int unsigned SHOT_CNT_W  = 16;
  localparam int unsigned FAULT_CNT_W = 8;
  localparam int unsigned FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    READY    = 2'd0,
    FIRE     = 2'd1,
    FLIGHT   = 2'd2,
    COOLDOWN = 2'd3
  } fire_state_t;

  // Increment v unless it has already reached max. Narrower counters
  // zero-extend into the 16-bit argument and truncate the result back.
  function automatic logic [15:0] sat_inc(input logic [15:0] v,
                                          input logic [15:0] max);
    logic [15:0] r;
    r = v;
    if (v < max) begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Press detector for a single keycode reported in either of two keyboard
// slots. Registers the "key down" level every frame and produces a one-frame
// press pulse on the frame where the key first appears.
// Ports:
//   frame_clk  frame clock
//   Reset_n    asynchronous active-low reset
//   keycode0   first reported key
//   keycode1   second reported key
//   press_c    combinational pulse: key down now, not down last frame
module key_edge_detect
  import si_pkg::*;
#(
  parameter logic [7:0] KEY = KEY_SPACE
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic       press_c
);

  logic key_now;
  logic key_prev;

  // Key counts as down if either keyboard slot reports it.
  assign key_now = (keycode0 == KEY) | (keycode1 == KEY);

  // Previous-frame key level.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      key_prev <= 1'b0;
    end else begin
      key_prev <= key_now;
    end
  end

  // Combinational so a key seen at edge k can launch a shot on edge k.
  assign press_c = key_now & ~key_prev;

endmodule

// File: rtl/fire_control.sv
// Fire control for the player bullet: converts raw keycodes into a
// single-shot request, using the bullet's loaded flag as acknowledge.
// Adds press edge detection, a one-deep pending-fire buffer, a post-reload
// cooldown and an acknowledge timeout. All outputs are registered.
// Ports:
//   frame_clk   frame clock
//   Reset_n     asynchronous active-low reset
//   enable      game-running qualifier; low forces READY and clears the request
//   keycode0/1  reported keys
//   loaded      1 = bullet parked, 0 = bullet in flight
//   shot        fire request to the bullet block
//   busy        state is not READY
//   pending     a buffered press is waiting
//   shot_count  acknowledged shots, saturating
//   ack_faults  abandoned requests, saturating
module fire_control
  import si_pkg::*;
#(
  parameter logic [7:0]  FIRE_KEY        = KEY_SPACE,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter int unsigned ACK_TIMEOUT     = 4,
  parameter int unsigned BUFFER_EN       = 1
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic        enable,
  input  logic [7:0]  keycode0,
  input  logic [7:0]  keycode1,
  input  logic        loaded,
  output logic        shot,
  output logic        busy,
  output logic        pending,
  output logic [15:0] shot_count,
  output logic [7:0]  ack_faults
);

  // Cooldown reload value; unused when there is no cooldown.
  localparam logic [FRAME_CNT_W-1:0] CD_LOAD =
    (COOLDOWN_FRAMES > 0) ? FRAME_CNT_W'(COOLDOWN_FRAMES - 1) : '0;
  // Last timeout count before the request is abandoned (ACK_TIMEOUT=0 acts as 1).
  localparam logic [FRAME_CNT_W-1:0] TO_LAST =
    (ACK_TIMEOUT > 1) ? FRAME_CNT_W'(ACK_TIMEOUT - 1) : '0;
  localparam logic NO_COOLDOWN = (COOLDOWN_FRAMES == 0);
  localparam logic BUF_ON      = (BUFFER_EN != 0);

  fire_state_t             state;
  logic [FRAME_CNT_W-1:0]  cd_cnt;
  logic [FRAME_CNT_W-1:0]  to_cnt;
  logic                    press;

  key_edge_detect #(
    .KEY (FIRE_KEY)
  ) u_fire_key (
    .frame_clk (frame_clk),
    .Reset_n   (Reset_n),
    .keycode0  (keycode0),
    .keycode1  (keycode1),
    .press_c   (press)
  );

  // Request sequencer with registered outputs.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= READY;
      shot       <= 1'b0;
      busy       <= 1'b0;
      pending    <= 1'b0;
      shot_count <= '0;
      ack_faults <= '0;
      cd_cnt     <= '0;
      to_cnt     <= '0;
    end else if (!enable) begin
      // Game halted: drop everything except the statistics.
      state   <= READY;
      shot    <= 1'b0;
      busy    <= 1'b0;
      pending <= 1'b0;
      cd_cnt  <= '0;
      to_cnt  <= '0;
    end else begin
      case (state)
        READY: begin
          if (loaded && (press || pending)) begin
            state   <= FIRE;
            shot    <= 1'b1;
            busy    <= 1'b1;
            pending <= 1'b0;
            to_cnt  <= '0;
          end else if (press && BUF_ON) begin
            pending <= 1'b1;
          end
        end

        FIRE: begin
          if (press && BUF_ON) begin
            pending <= 1'b1;
          end
          // Acknowledge is checked first so it wins over a same-edge timeout.
          if (!loaded) begin
            state      <= FLIGHT;
            shot       <= 1'b0;
            shot_count <= sat_inc(shot_count, 16'hFFFF);
          end else if (to_cnt == TO_LAST) begin
            state      <= READY;
            shot       <= 1'b0;
            busy       <= 1'b0;
            ack_faults <= FAULT_CNT_W'(sat_inc(16'(ack_faults), 16'h00FF));
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        FLIGHT: begin
          // A press on the reload edge is buffered, never fired directly.
          if (press && BUF_ON) begin
            pending <= 1'b1;
          end
          if (loaded) begin
            if (NO_COOLDOWN) begin
              state <= READY;
              busy  <= 1'b0;
            end else begin
              state  <= COOLDOWN;
              cd_cnt <= CD_LOAD;
            end
          end
        end

        COOLDOWN: begin
          if (press && BUF_ON) begin
            pending <= 1'b1;
          end
          // Leave on the edge the counter reaches zero so a pending press
          // is served on the very next READY evaluation.
          if (cd_cnt <= FRAME_CNT_W'(1)) begin
            state  <= READY;
            busy   <= 1'b0;
            cd_cnt <= '0;
          end else begin
            cd_cnt <= cd_cnt - 1'b1;
          end
        end

        default: begin
          state <= READY;
          shot  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fire_control.sv
module tb_fire_control;

  logic        frame_clk = 1'b0;
  logic        Reset_n;
  logic        enable;
  logic [7:0]  keycode0;
  logic [7:0]  keycode1;
  logic        loaded;

  logic        shot_a, busy_a, pending_a;
  logic [15:0] shot_count_a;
  logic [7:0]  ack_faults_a;
  logic        shot_b, busy_b, pending_b;
  logic [15:0] shot_count_b;
  logic [7:0]  ack_faults_b;

  int checks = 0;
  int errors = 0;

  always #5 frame_clk = ~frame_clk;

  // Default build: cooldown 8, timeout 4, buffering on.
  fire_control dut_a (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .enable     (enable),
    .keycode0   (keycode0),
    .keycode1   (keycode1),
    .loaded     (loaded),
    .shot       (shot_a),
    .busy       (busy_a),
    .pending    (pending_a),
    .shot_count (shot_count_a),
    .ack_faults (ack_faults_a)
  );

  // Variant: no cooldown, timeout 2, buffering off.
  fire_control #(
    .FIRE_KEY        (8'h2C),
    .COOLDOWN_FRAMES (0),
    .ACK_TIMEOUT     (2),
    .BUFFER_EN       (0)
  ) dut_b (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .enable     (enable),
    .keycode0   (keycode0),
    .keycode1   (keycode1),
    .loaded     (loaded),
    .shot       (shot_b),
    .busy       (busy_b),
    .pending    (pending_b),
    .shot_count (shot_count_b),
    .ack_faults (ack_faults_b)
  );

  // Behavioural reference: mode 0 idle, 1 requesting, 2 bullet out, 3 cooling.
  // age = frames the request has been shown; cool_left = cooling frames left.
  typedef struct {
    int mode;
    int age;
    int cool_left;
    bit pend;
    int shots;
    int faults;
    bit kprev;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.mode = 0; r.age = 0; r.cool_left = 0; r.pend = 0;
    r.shots = 0; r.faults = 0; r.kprev = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_next(mdl_t m, bit en, bit kn, bit ld,
                                    int cd, int to, bit bufen);
    mdl_t n = m;
    bit press = kn & ~m.kprev;
    n.kprev = kn;
    if (!en) begin
      n.mode = 0; n.pend = 0; n.age = 0; n.cool_left = 0;
      return n;
    end
    if (m.mode == 0) begin
      if (ld && (press || m.pend)) begin
        n.mode = 1; n.age = 1; n.pend = 0;
      end else if (press && bufen) begin
        n.pend = 1;
      end
      return n;
    end
    if (press && bufen) n.pend = 1;
    if (m.mode == 1) begin
      if (!ld) begin
        n.mode = 2;
        if (m.shots < 65535) n.shots = m.shots + 1;
      end else if (m.age >= to) begin
        n.mode = 0;
        if (m.faults < 255) n.faults = m.faults + 1;
      end else begin
        n.age = m.age + 1;
      end
    end else if (m.mode == 2) begin
      if (ld) begin
        if (cd == 0) n.mode = 0;
        else begin
          n.mode = 3;
          n.cool_left = (cd > 1) ? cd - 1 : 1;
        end
      end
    end else begin
      n.cool_left = m.cool_left - 1;
      if (n.cool_left <= 0) n.mode = 0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("a_shot",    32'(shot_a),       32'(ma.mode == 1));
    chk("a_busy",    32'(busy_a),       32'(ma.mode != 0));
    chk("a_pending", 32'(pending_a),    32'(ma.pend));
    chk("a_shots",   32'(shot_count_a), 32'(ma.shots));
    chk("a_faults",  32'(ack_faults_a), 32'(ma.faults));
    chk("b_shot",    32'(shot_b),       32'(mb.mode == 1));
    chk("b_busy",    32'(busy_b),       32'(mb.mode != 0));
    chk("b_pending", 32'(pending_b),    32'(mb.pend));
    chk("b_shots",   32'(shot_count_b), 32'(mb.shots));
    chk("b_faults",  32'(ack_faults_b), 32'(mb.faults));
  endtask

  // One frame: drive at negedge, model the rising edge, check at next negedge.
  task automatic frame(input bit en, input logic [7:0] k0, input logic [7:0] k1,
                       input bit ld);
    bit kn;
    enable = en; keycode0 = k0; keycode1 = k1; loaded = ld;
    @(posedge frame_clk);
    kn = (k0 == 8'h2C) || (k1 == 8'h2C);
    ma = mdl_next(ma, en, kn, ld, 8, 4, 1'b1);
    mb = mdl_next(mb, en, kn, ld, 0, 2, 1'b0);
    @(negedge frame_clk);
    compare_all();
  endtask

  // Reset asserted between edges: outputs must clear without a clock.
  task automatic mid_reset();
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_shot_a",  32'(shot_a), 32'd0);
    chk("rst_shot_b",  32'(shot_b), 32'd0);
    chk("rst_count_a", 32'(shot_count_a), 32'd0);
    chk("rst_fault_a", 32'(ack_faults_a), 32'd0);
    ma = mdl_reset();
    mb = mdl_reset();
    @(negedge frame_clk);
    Reset_n = 1'b1;
    compare_all();
  endtask

  localparam logic [7:0] SP = 8'h2C;
  localparam logic [7:0] NK = 8'h00;

  initial begin
    Reset_n = 1'b0; enable = 1'b0; keycode0 = NK; keycode1 = NK; loaded = 1'b1;
    ma = mdl_reset();
    mb = mdl_reset();
    @(negedge frame_clk);
    @(negedge frame_clk);
    compare_all();
    Reset_n = 1'b1;

    // First shot, key held, ack.
    frame(1, NK, NK, 1);
    frame(1, NK, NK, 1);
    frame(1, SP, NK, 1);
    chk("first_shot", 32'(shot_a), 32'd1);
    frame(1, SP, NK, 1);
    frame(1, SP, NK, 0);
    chk("first_ack_count", 32'(shot_count_a), 32'd1);
    repeat (10) frame(1, SP, NK, 0);
    repeat (5)  frame(1, SP, NK, 1);
    frame(1, NK, NK, 1);
    // Re-press during cooldown is buffered and served after cooldown.
    frame(1, NK, SP, 1);
    chk("cool_pending", 32'(pending_a), 32'd1);
    repeat (4) frame(1, NK, SP, 1);
    frame(1, NK, SP, 0);
    chk("second_count", 32'(shot_count_a), 32'd2);

    // Timeout with loaded held high.
    repeat (10) frame(1, NK, NK, 1);
    frame(1, SP, NK, 1);
    repeat (4) frame(1, SP, NK, 1);
    chk("timeout_faults", 32'(ack_faults_a), 32'd1);
    chk("timeout_shot",   32'(shot_a), 32'd0);

    // Two presses in flight collapse to one pending shot.
    repeat (3) frame(1, NK, NK, 1);
    frame(1, SP, NK, 1);
    frame(1, NK, NK, 0);
    frame(1, SP, NK, 0);
    frame(1, NK, NK, 0);
    frame(1, SP, NK, 0);
    frame(1, NK, NK, 0);
    repeat (9) frame(1, NK, NK, 1);
    frame(1, NK, NK, 0);
    repeat (12) frame(1, NK, NK, 1);

    // Press in flight with reload on the same edge, then enable drop in cooldown.
    frame(1, SP, NK, 1);
    frame(1, NK, NK, 0);
    frame(1, SP, NK, 1);
    frame(1, NK, NK, 1);
    frame(0, NK, NK, 1);
    frame(0, SP, NK, 1);
    frame(0, NK, NK, 1);
    frame(1, NK, NK, 1);

    // Reset in the middle of a request, then a fresh press.
    frame(1, SP, NK, 1);
    mid_reset();
    frame(1, NK, NK, 1);
    frame(1, SP, NK, 1);
    frame(1, SP, NK, 0);
    repeat (4) frame(1, NK, NK, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] k0, k1;
      bit en, ld;
      k0 = ($urandom_range(0, 2) == 0) ? SP : 8'($urandom_range(0, 255));
      k1 = ($urandom_range(0, 5) == 0) ? SP : 8'($urandom_range(0, 255));
      en = ($urandom_range(0, 39) != 0);
      ld = ($urandom_range(0, 3) != 0);
      frame(en, k0, k1, ld);
      if ($urandom_range(0, 599) == 0) mid_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fire_control.md
Name: fire_control

Overview:
- Upstream stage of the player bullet block. Turns the raw keyboard keycodes into a clean, single-shot `shot` request.
- Uses the bullet block's `loaded` flag as the acknowledge.
- Provides press edge detection, a one-deep pending-fire buffer, a post-impact cooldown and an acknowledge timeout.
- Clocked at frame rate. Its `shot` output drives the bullet block's `shot` input directly.

Parameters:
- FIRE_KEY, 8'h2C, USB HID keycode that fires (space).
- COOLDOWN_FRAMES, 8, frames to wait after the bullet reloads before the next fire; 0 means no cooldown.
- ACK_TIMEOUT, 4, frames `shot` may stay high without `loaded` falling before the request is abandoned.
- BUFFER_EN, 1, 1 allows one press during FLIGHT/COOLDOWN to be queued.

Ports:
- frame_clk  in  1  frame clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  game-running qualifier (BuGo).
- keycode0  in  8  first reported key.
- keycode1  in  8  second reported key.
- loaded  in  1  from bullet: 1 means bullet parked and available, 0 means in flight.
- shot  out  1  fire request to bullet.
- busy  out  1  high in any state other than READY.
- pending  out  1  a buffered press is waiting.
- shot_count  out  16  accepted (acknowledged) shots, saturating.
- ack_faults  out  8  timed-out requests, saturating.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=READY; shot=0, pending=0, busy=0.
  - shot_count=0, ack_faults=0; key_prev=0; cooldown counter=0; timeout counter=0.
- Key detection:
  - key_now = (keycode0==FIRE_KEY) | (keycode1==FIRE_KEY).
  - key_prev registered every edge.
  - press = key_now & ~key_prev. Holding the key never repeats.
- All outputs are registered.
- READY:
  - If enable & loaded & (press | pending): go to FIRE, shot=1, pending=0, timeout counter=0.
  - A press with loaded=0 sets pending (if BUFFER_EN) and stays in READY.
  - Latency: key down visible at edge k means shot=1 after edge k.
- FIRE (shot=1):
  - loaded==0 sampled: go to FLIGHT, shot=0, shot_count+1 (saturate at 16'hFFFF).
  - Else the timeout counter increments. When it reaches ACK_TIMEOUT-1 with loaded still 1: go to READY, shot=0, ack_faults+1 (saturate at 8'hFF).
- FLIGHT:
  - Wait for loaded==1.
  - Then go to COOLDOWN with counter=COOLDOWN_FRAMES-1, or straight to READY if COOLDOWN_FRAMES==0.
- COOLDOWN:
  - Counter decrements each frame; at 0 go to READY.
  - Pending is served on the first READY cycle; no extra frame is lost beyond the READY evaluation.
- Buffering:
  - A press in FIRE, FLIGHT or COOLDOWN sets pending when BUFFER_EN=1, otherwise it is ignored.
  - Additional presses while pending=1 are dropped (depth 1, no counting).
- enable=0 in any state, synchronous:
  - Next state READY; shot=0, pending=0, counters cleared.
  - shot_count and ack_faults are held.
- Simultaneous events:
  - In FIRE, loaded falling and timeout expiry on the same edge: acknowledge wins.
  - In FLIGHT, a press on the same edge loaded rises: the press is buffered, not fired directly.
- busy = (state != READY).
- Reset mid-FIRE drops shot immediately (asynchronously).

Decomposition:
- Shared package `si_pkg`:
  - State enum fire_state_t {READY, FIRE, FLIGHT, COOLDOWN}.
  - KEY_SPACE=8'h2C.
  - Saturating-increment function, reused for score counters.
- One natural sub-module: `key_edge_detect`, covering the keycode compare, key_prev register and press pulse. It is reusable for the pause/start keys.

Test Plan:
- Reset then enable=1, loaded=1, keycode0=8'h2C at frame 3 → shot=1 after frame 3 edge only. Hold key 20 frames → exactly one shot. loaded→0 at frame 5 → shot=0, shot_count=1, state FLIGHT.
- COOLDOWN_FRAMES=8: loaded→1 at frame 30, key re-pressed at 32 → pending=1, busy=1 through frame 37. shot=1 after frame 38 edge; shot_count=2.
- ACK_TIMEOUT=4, loaded held at 1 after fire → shot high for 4 frames, then 0. ack_faults=1, state READY, shot_count unchanged.
- Two presses during FLIGHT with BUFFER_EN=1 → only one pending shot after reload. With BUFFER_EN=0 → no shot until a fresh press in READY.
- enable dropped during COOLDOWN with pending=1 → next edge READY, pending=0, shot_count held. Press with enable=0 → no shot.
- Reset_n pulsed low mid-FIRE (between edges) → shot=0 immediately; all counters 0. Key released and re-pressed after reset → normal fire.
